// File: rtl/timer_ctrl_pkg.sv
// Shared types and defaults for the timer_ctrl block.
package timer_ctrl_pkg;

  localparam int unsigned TIMER_CTRL_WIDTH = 4;
  localparam int unsigned PERIODS_W        = 4;
  localparam int unsigned PRESC_W          = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/timer_ctrl_counter_core.sv
// WIDTH-bit up-counter register with synchronous clear and count enable.
module counter_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// One-shot / periodic terminal-count timer with IDLE/RUN control FSM.
// Optional prescaler enabled by defining TIMER_CTRL_PRESCALE_EN.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = TIMER_CTRL_WIDTH
`ifdef TIMER_CTRL_PRESCALE_EN
  ,
  parameter int unsigned PRESCALE = 2
`endif
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     tc,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     count,
  output logic [PERIODS_W-1:0] periods
);

  state_t               state, state_nxt;
  logic                 done_nxt;
  logic [PERIODS_W-1:0] periods_nxt;
  logic [WIDTH-1:0]     tc_q, tc_nxt;
  logic                 mode_q, mode_nxt;
  logic                 count_clr, count_en;
  logic                 step;

`ifdef TIMER_CTRL_PRESCALE_EN
  logic [PRESC_W-1:0]   presc, presc_nxt;

  assign step = (presc == PRESC_W'(PRESCALE - 1));
`else
  assign step = 1'b1;
`endif

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clk  (clk),
    .rstn (rstn),
    .clr  (count_clr),
    .en   (count_en),
    .q    (count)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      periods <= '0;
      tc_q    <= '0;
      mode_q  <= 1'b0;
`ifdef TIMER_CTRL_PRESCALE_EN
      presc   <= '0;
`endif
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt == RUN);
      done    <= done_nxt;
      periods <= periods_nxt;
      tc_q    <= tc_nxt;
      mode_q  <= mode_nxt;
`ifdef TIMER_CTRL_PRESCALE_EN
      presc   <= presc_nxt;
`endif
    end
  end

  // Next-state and counter control
  always_comb begin
    state_nxt   = state;
    done_nxt    = 1'b0;
    periods_nxt = periods;
    tc_nxt      = tc_q;
    mode_nxt    = mode_q;
    count_clr   = 1'b0;
    count_en    = 1'b0;
`ifdef TIMER_CTRL_PRESCALE_EN
    presc_nxt   = presc;
`endif
    case (state)
      IDLE: begin
        count_clr = 1'b1;
        if (start && !stop) begin
          state_nxt   = RUN;
          tc_nxt      = tc;
          mode_nxt    = mode;
          periods_nxt = '0;
`ifdef TIMER_CTRL_PRESCALE_EN
          presc_nxt   = '0;
`endif
        end
      end
      RUN: begin
        // stop wins over a coincident terminal count
        if (stop) begin
          state_nxt = IDLE;
          count_clr = 1'b1;
`ifdef TIMER_CTRL_PRESCALE_EN
          presc_nxt = '0;
`endif
        end else begin
`ifdef TIMER_CTRL_PRESCALE_EN
          presc_nxt = step ? '0 : presc + PRESC_W'(1);
`endif
          if (step) begin
            if (count == tc_q) begin
              done_nxt  = 1'b1;
              count_clr = 1'b1;
              if (!mode_q) begin
                state_nxt = IDLE;
              end else if (periods != {PERIODS_W{1'b1}}) begin
                periods_nxt = periods + PERIODS_W'(1);
              end
            end else begin
              count_en = 1'b1;
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        count_clr = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl.
module tb_timer_ctrl;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rstn;
  logic             start;
  logic             stop;
  logic             mode;
  logic [WIDTH-1:0] tc;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count;
  logic [3:0]       periods;

  int vectors;
  int miscompares;

`ifdef TIMER_CTRL_PRESCALE_EN
  timer_ctrl #(.WIDTH(WIDTH), .PRESCALE(3)) dut (
`else
  timer_ctrl #(.WIDTH(WIDTH)) dut (
`endif
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .stop    (stop),
    .mode    (mode),
    .tc      (tc),
    .busy    (busy),
    .done    (done),
    .count   (count),
    .periods (periods)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic b, input logic d,
                         input logic [WIDTH-1:0] c, input logic [3:0] p);
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".periods"}, 32'(periods), 32'(p));
  endtask

  task automatic launch(input logic m, input logic [WIDTH-1:0] t);
    start = 1'b1;
    mode  = m;
    tc    = t;
    tick();
    start = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    mode  = 1'b0;
    tc    = '0;
    tick();
    tick();
    chk_all("reset", 1'b0, 1'b0, 4'd0, 4'd0);
    rstn = 1'b1;
    tick();
    chk_all("idle", 1'b0, 1'b0, 4'd0, 4'd0);

`ifndef TIMER_CTRL_PRESCALE_EN
    // one-shot tc=5: busy 6 cycles, single done
    launch(1'b0, 4'd5);
    chk_all("os5.k0", 1'b1, 1'b0, 4'd0, 4'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_all("os5.run", 1'b1, 1'b0, 4'(k), 4'd0);
    end
    tick();
    chk_all("os5.done", 1'b0, 1'b1, 4'd0, 4'd0);
    tick();
    chk_all("os5.after", 1'b0, 1'b0, 4'd0, 4'd0);

    // periodic tc=3 for 12 steps, then stop keeps periods
    launch(1'b1, 4'd3);
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk_all("per3", 1'b1, (i % 4) == 0, 4'(i % 4), 4'(i / 4));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("per3.stop", 1'b0, 1'b0, 4'd0, 4'd3);

    // periodic tc=0: done every step, periods saturates
    launch(1'b1, 4'd0);
    chk_all("per0.k0", 1'b1, 1'b0, 4'd0, 4'd0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk_all("per0", 1'b1, 1'b1, 4'd0, (i > 15) ? 4'd15 : 4'(i));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("per0.stop", 1'b0, 1'b0, 4'd0, 4'd15);

    // one-shot tc=0: one busy cycle then done
    launch(1'b0, 4'd0);
    chk_all("os0.k0", 1'b1, 1'b0, 4'd0, 4'd0);
    tick();
    chk_all("os0.done", 1'b0, 1'b1, 4'd0, 4'd0);

    // one-shot tc=9 stopped at count 4
    launch(1'b0, 4'd9);
    for (int k = 1; k <= 4; k++) tick();
    chk("os9.cnt4", 32'(count), 32'd4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("os9.stop", 1'b0, 1'b0, 4'd0, 4'd0);
    tick();
    chk("os9.nodone", 32'(done), 32'd0);

    // stop coincident with terminal count
    launch(1'b0, 4'd2);
    tick();
    tick();
    chk("stoptc.cnt", 32'(count), 32'd2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("stoptc", 1'b0, 1'b0, 4'd0, 4'd0);
    tick();
    chk("stoptc.nodone", 32'(done), 32'd0);

    // start+stop together in IDLE stays IDLE
    start = 1'b1;
    stop  = 1'b1;
    tc    = 4'd3;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk_all("startstop", 1'b0, 1'b0, 4'd0, 4'd0);

    // tc/mode change and start during RUN are ignored
    launch(1'b0, 4'd6);
    start = 1'b1;
    tc    = 4'd2;
    mode  = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_all("ign.run", 1'b1, 1'b0, 4'(k), 4'd0);
    end
    start = 1'b0;
    tick();
    chk_all("ign.done", 1'b0, 1'b1, 4'd0, 4'd0);
    tick();
    chk_all("ign.idle", 1'b0, 1'b0, 4'd0, 4'd0);

    // all-ones tc counts to 15 without wrap
    launch(1'b0, 4'd15);
    for (int k = 1; k <= 15; k++) tick();
    chk_all("tc15.top", 1'b1, 1'b0, 4'd15, 4'd0);
    tick();
    chk_all("tc15.done", 1'b0, 1'b1, 4'd0, 4'd0);

    // reset at count 7 overrides inputs, no done
    launch(1'b1, 4'd15);
    for (int k = 1; k <= 7; k++) tick();
    chk("rst.cnt7", 32'(count), 32'd7);
    rstn  = 1'b0;
    start = 1'b1;
    tick();
    chk_all("rst.mid", 1'b0, 1'b0, 4'd0, 4'd0);
    start = 1'b0;
    rstn  = 1'b1;
    tick();
    chk_all("rst.after", 1'b0, 1'b0, 4'd0, 4'd0);
`else
    // prescale 3, tc=2 one-shot: done 9 clocks after start edge
    begin
      int n;
      launch(1'b0, 4'd2);
      n = 0;
      while (!done && n < 40) begin
        tick();
        n++;
      end
      chk("presc.latency", 32'(n), 32'd9);
      chk_all("presc.done", 1'b0, 1'b1, 4'd0, 4'd0);
      tick();
      chk_all("presc.idle", 1'b0, 1'b0, 4'd0, 4'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
